traffic_scheduler: RTL
======================

# traffic_scheduler

Phase scheduler for the highway/country-road intersection, adding a pedestrian crossing phase. It sequences the two road lights and a walk signal through timed green, yellow and all-red-walk phases. Minimum and maximum green times are enforced, and the country-road sensor and the pedestrian button are arbitrated against the default highway-green phase. It is the top-level sequencer: its light outputs drive the signal heads directly.

## Interface

Parameters:
- MIN_GREEN, 4: minimum green dwell in cycles for either road (≥1).
- MAX_GREEN, 8: maximum country green dwell in cycles (≥ MIN_GREEN).
- YELLOW_TIME, 2: yellow dwell in cycles (≥1).
- WALK_TIME, 3: pedestrian all-red walk dwell in cycles (≥1).
- CNT_W, 4: phase timer width; every dwell parameter must be ≤ 2^CNT_W.

Ports:
- clk, input, 1: single clock, all state updates on its rising edge.
- rst, input, 1: reset, **synchronous, active-low**.
- x, input, 1: country-road car sensor, level, synchronous to clk.
- ped_req, input, 1: pedestrian button, single- or multi-cycle pulse.
- Highway, output, 2: highway light (green=00, red=01, yellow=10).
- Country, output, 2: country light (same encoding).
- walk, output, 1: pedestrian walk lamp.
- state, output, 3: current phase, for debug and the bench.

## Operation

- States:
  - HG: highway green / country red.
  - HY: highway yellow / country red.
  - CG: highway red / country green.
  - CY: highway red / country yellow.
  - PW: both red, walk=1.
- Lights and walk are a pure decode of the state register. Code 11 is never driven.
- ped_pending flag:
  - Set by ped_req=1.
  - Cleared on the edge entering PW.
  - If set and clear occur on the same edge, set wins (flag stays 1).
- Phase timer:
  - Cleared to 0 on every state change.
  - Otherwise increments each cycle, saturating at 2^CNT_W−1.
- Transitions are evaluated each cycle; t is the timer value.
  - HG → HY: when t ≥ MIN_GREEN−1 and (x or ped_pending). Otherwise hold HG indefinitely.
  - HY → PW if ped_pending, else → CG: when t = YELLOW_TIME−1.
  - CG → CY: when t ≥ MIN_GREEN−1 and (!x or ped_pending), or when t = MAX_GREEN−1 regardless of inputs.
  - CY → PW if ped_pending, else → HG: when t = YELLOW_TIME−1.
  - PW → HG: when t = WALK_TIME−1. Always returns to the highway, never to CG.
- x dropping during HY does not abort the phase; CG is still entered and left after MIN_GREEN.
- Reset (rst=0 at an edge), from any state and mid-phase:
  - state=HG, t=0, ped_pending=0.
  - Highway=00, Country=01, walk=0.

## Timing

- Every output is valid in the cycle after the edge that updates state; no further pipeline stages.
- Dwell counts below are in cycles; "edge" is a rising clock edge.
- HG dwell:
  - Exactly MIN_GREEN if a request is present from entry.
  - Otherwise the HG→HY edge is the edge after the first cycle in which t ≥ MIN_GREEN−1 and a request is present.
- Yellow dwell: exactly YELLOW_TIME.
- Walk dwell: exactly WALK_TIME.
- CG dwell: between MIN_GREEN and MAX_GREEN inclusive.
- ped_req sampled at edge k:
  - ped_pending=1 from cycle k+1.
  - Earliest effect on state is at edge k+1.
- Inputs have no combinational path to outputs.

## Structure

- Shared package traffic_pkg:
  - Light encoding constants GREEN/RED/YELLOW.
  - Phase state enum (HG, HY, CG, CY, PW).
  - Both reused by the existing light controller.
- Sub-module phase_timer:
  - CNT_W-bit counter with synchronous clear and saturation.
  - Same clk and rst.
- The top contains the next-state logic, the ped_pending latch and the output decode.

## Test plan

- Reset, idle (x=0, ped_req=0 for 20 cycles): state stays HG; Highway=00, Country=01, walk=0 throughout.
- Car request from reset (x=1 held, defaults): HG 4 → HY 2 → CG 8 (capped by MAX_GREEN) → CY 2 → HG 4 → HY …
- Car leaves early (x=1 for 7 cycles, then 0): CG exits after exactly 4 cycles, then CY 2, then HG.
- Pedestrian pulse (1-cycle ped_req in HG at t=1, x=0): HY at the edge after t=3, then PW 3 cycles with walk=1, then HG; ped_pending=0 after PW entry.
- Pedestrian during CG (x=1, ped_req mid-CG after t ≥ 3): CY, then PW, then HG; CG not re-entered before HG.
- rst=0 asserted for 1 cycle mid-CY: next cycle state=HG, t=0, outputs 00/01/0, pending cleared.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection light controllers: light codes and phase states.
package traffic_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] RED    = 2'b01;
    localparam logic [1:0] YELLOW = 2'b10;

    typedef enum logic [2:0] {
        HG = 3'd0,
        HY = 3'd1,
        CG = 3'd2,
        CY = 3'd3,
        PW = 3'd4
    } phase_e;

endpackage

// File: rtl/phase_timer.sv
// Phase dwell counter: synchronous clear, saturating increment.
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] t
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign t = cnt_q;

endmodule

// File: rtl/traffic_scheduler.sv
// Highway/country/pedestrian phase sequencer; light outputs are a decode of the phase register.
module traffic_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 8,
    parameter int YELLOW_TIME = 2,
    parameter int WALK_TIME   = 3,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       x,
    input  logic       ped_req,
    output logic [1:0] Highway,
    output logic [1:0] Country,
    output logic       walk,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] MIN_T  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_T  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_T  = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] WALK_T = CNT_W'(WALK_TIME - 1);

    phase_e           state_q, state_d;
    logic             ped_pending_q, ped_pending_d;
    logic             timer_clr;
    logic [CNT_W-1:0] t;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .t   (t)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            HG: if (t >= MIN_T && (x || ped_pending_q)) state_d = HY;
            HY: if (t == YEL_T) state_d = ped_pending_q ? PW : CG;
            CG: if ((t >= MIN_T && (!x || ped_pending_q)) || t == MAX_T) state_d = CY;
            CY: if (t == YEL_T) state_d = ped_pending_q ? PW : HG;
            PW: if (t == WALK_T) state_d = HG;
            default: state_d = HG;
        endcase
        timer_clr = (state_d != state_q);
        // A press on the same edge that enters the walk phase is kept for the next cycle.
        ped_pending_d = ped_req | (ped_pending_q & ~(state_d == PW && state_q != PW));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= HG;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    always_comb begin
        Highway = RED;
        Country = RED;
        walk    = 1'b0;
        case (state_q)
            HG: Highway = GREEN;
            HY: Highway = YELLOW;
            CG: Country = GREEN;
            CY: Country = YELLOW;
            PW: walk    = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule
